// File: rtl/mult_shiftadd_ctrl.sv
// rtl/mult_shiftadd_ctrl.sv - shift-and-add multiply sequencer driving a shared regfile/ALU datapath
module mult_shiftadd_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic                     sStart,
    input  logic                     sPar,
    input  logic                     sZero,
    input  logic                     sCarry,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     sBusy,
    output logic                     sDone,
    output logic                     sOvf
);

    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [SELECTIONDECO-1:0] REG_R0   = SELECTIONDECO'(0);
    localparam logic [SELECTIONDECO-1:0] REG_R1   = SELECTIONDECO'(1);
    localparam logic [SELECTIONDECO-1:0] REG_R2   = SELECTIONDECO'(2);
    localparam logic [SELECTIONDECO-1:0] REG_R6   = SELECTIONDECO'(6);
    localparam logic [SELECTIONDECO-1:0] REG_R7   = SELECTIONDECO'(7);
    localparam logic [SELECTIONDECO-1:0] NO_WRITE = SELECTIONDECO'(7);

    localparam logic [SELECTIONALU-1:0] ALU_PASSA = SELECTIONALU'(3'b000);
    localparam logic [SELECTIONALU-1:0] ALU_ADD   = SELECTIONALU'(3'b001);
    localparam logic [SELECTIONALU-1:0] ALU_SUB   = SELECTIONALU'(3'b010);
    localparam logic [SELECTIONALU-1:0] ALU_SHL   = SELECTIONALU'(3'b100);
    localparam logic [SELECTIONALU-1:0] ALU_SHR   = SELECTIONALU'(3'b101);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_LDA,
        S_LDB,
        S_TEST,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (lowRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        sSelDecoA = REG_R0;
        sSelDecoB = REG_R0;
        sSelDecoC = NO_WRITE;
        sSelAlu   = ALU_PASSA;

        case (state_q)
            S_IDLE: begin
                if (sStart) begin
                    state_d = S_CLR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            // R6 - R6 gives a zero without needing a constant port on the datapath
            S_CLR: begin
                sSelDecoA = REG_R6;
                sSelDecoB = REG_R6;
                sSelDecoC = REG_R0;
                sSelAlu   = ALU_SUB;
                state_d   = S_LDA;
            end
            S_LDA: begin
                sSelDecoA = REG_R6;
                sSelDecoC = REG_R1;
                state_d   = S_LDB;
            end
            S_LDB: begin
                sSelDecoA = REG_R7;
                sSelDecoC = REG_R2;
                state_d   = S_TEST;
            end
            S_TEST: begin
                sSelDecoA = REG_R2;
                if (sZero || (cnt_q == CNTW'(WIDTH))) begin
                    state_d = S_DONE;
                end else if (!sPar) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end
            // A previously lost multiplicand bit makes this partial product overflow too
            S_ADD: begin
                sSelDecoA = REG_R0;
                sSelDecoB = REG_R1;
                sSelDecoC = REG_R0;
                sSelAlu   = ALU_ADD;
                if (sCarry || pend_q) begin
                    ovf_d = 1'b1;
                end
                state_d = S_SHL;
            end
            S_SHL: begin
                sSelDecoA = REG_R1;
                sSelDecoC = REG_R1;
                sSelAlu   = ALU_SHL;
                if (sCarry) begin
                    pend_d = 1'b1;
                end
                state_d = S_SHR;
            end
            S_SHR: begin
                sSelDecoA = REG_R2;
                sSelDecoC = REG_R2;
                sSelAlu   = ALU_SHR;
                cnt_d     = cnt_q + CNTW'(1);
                state_d   = S_TEST;
            end
            S_DONE: begin
                if (!sStart) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sBusy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign sDone = (state_q == S_DONE);
    assign sOvf  = ovf_q;

endmodule

// File: tb/tb_mult_shiftadd_ctrl.sv
// tb/tb_mult_shiftadd_ctrl.sv - self-checking bench with a register-file/ALU model and result scoreboard
module tb_mult_shiftadd_ctrl;

    logic       clk = 1'b0;
    logic       lowRst;
    logic       sStart;
    logic       sPar, sZero, sCarry;
    logic [2:0] sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu;
    logic       sBusy, sDone, sOvf;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] r0, r1, r2, r6, r7;
    logic [7:0] opa, opb, res;
    logic       cy;

    typedef struct {
        logic [7:0] r0;
        logic       ovf;
        int         lat;
        int         adds;
    } exp_t;

    exp_t sb[$];

    mult_shiftadd_ctrl #(
        .WIDTH(8),
        .SELECTIONALU(3),
        .SELECTIONDECO(3)
    ) dut (
        .clk      (clk),
        .lowRst   (lowRst),
        .sStart   (sStart),
        .sPar     (sPar),
        .sZero    (sZero),
        .sCarry   (sCarry),
        .sSelDecoA(sSelDecoA),
        .sSelDecoB(sSelDecoB),
        .sSelDecoC(sSelDecoC),
        .sSelAlu  (sSelAlu),
        .sBusy    (sBusy),
        .sDone    (sDone),
        .sOvf     (sOvf)
    );

    always #5 clk = ~clk;

    // Datapath model: register file read ports A/B, ALU, flags
    always_comb begin
        case (sSelDecoA)
            3'd0: opa = r0;
            3'd1: opa = r1;
            3'd2: opa = r2;
            3'd6: opa = r6;
            3'd7: opa = r7;
            default: opa = 8'd0;
        endcase
        case (sSelDecoB)
            3'd0: opb = r0;
            3'd1: opb = r1;
            3'd2: opb = r2;
            3'd6: opb = r6;
            3'd7: opb = r7;
            default: opb = 8'd0;
        endcase
        case (sSelAlu)
            3'b001: {cy, res} = {1'b0, opa} + {1'b0, opb};
            3'b010: {cy, res} = {1'b0, opa} - {1'b0, opb};
            3'b100: {cy, res} = {opa[7], opa[6:0], 1'b0};
            3'b101: {cy, res} = {opa[0], 1'b0, opa[7:1]};
            default: {cy, res} = {1'b0, opa};
        endcase
    end

    assign sPar   = ~res[0];
    assign sZero  = (res == 8'd0);
    assign sCarry = cy;

    always @(posedge clk) begin
        case (sSelDecoC)
            3'd0: r0 <= res;
            3'd1: r1 <= res;
            3'd2: r2 <= res;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [7:0] b);
        int         l;
        logic [7:0] t;
        l = 4;
        t = b;
        while (t != 8'd0) begin
            l += t[0] ? 4 : 3;
            t = t >> 1;
        end
        return l;
    endfunction

    // pulse=1: drop sStart after the start edge and pulse it mid-run
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit pulse);
        exp_t e;
        int   cyc;
        int   adds;
        bit   busy_ok;
        e.r0   = a * b;
        e.ovf  = ((a * b) > 255);
        e.lat  = exp_latency(b);
        e.adds = $countones(b);
        @(negedge clk);
        r6 = a;
        r7 = b;
        sStart = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        cyc = 0;
        adds = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        if (pulse) sStart = 1'b0;
        while (cyc < 100) begin
            if (!sBusy || sDone) busy_ok = 1'b0;
            if (sSelAlu == 3'b001) adds++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (pulse) sStart = (cyc == 5);
            if (sDone) break;
        end
        e = sb.pop_front();
        check($sformatf("latency %0d*%0d", a, b), cyc, e.lat);
        check($sformatf("done %0d*%0d", a, b), sDone, 1'b1);
        check($sformatf("r0 %0d*%0d", a, b), r0, e.r0);
        check($sformatf("ovf %0d*%0d", a, b), sOvf, e.ovf);
        check($sformatf("adds %0d*%0d", a, b), adds, e.adds);
        check($sformatf("busy %0d*%0d", a, b), busy_ok, 1'b1);
        sStart = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("hold_done", {sDone, sBusy}, 2'b10);
        sStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_drop", {sDone, sBusy}, 2'b00);
        check("ovf_held_idle", sOvf, e.ovf);
    endtask

    initial begin
        int adds;
        lowRst = 1'b1;
        sStart = 1'b0;
        r6 = 8'd0;
        r7 = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", sBusy, 1'b0);
        check("rst_done", sDone, 1'b0);
        check("rst_ovf", sOvf, 1'b0);
        check("rst_selc", sSelDecoC, 3'b111);
        check("rst_alu", sSelAlu, 3'b000);
        lowRst = 1'b0;

        run_mul(8'd5, 8'd3, 1'b0);
        run_mul(8'd9, 8'd0, 1'b0);
        run_mul(8'd200, 8'd2, 1'b0);
        run_mul(8'd255, 8'd255, 1'b0);
        run_mul(8'd5, 8'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end

        // Reset during the second ADD of 5*3
        @(negedge clk);
        r6 = 8'd5;
        r7 = 8'd3;
        sStart = 1'b1;
        @(posedge clk);
        adds = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sSelAlu == 3'b001) adds++;
            if (adds == 2) break;
            @(posedge clk);
        end
        check("rst_found_add2", adds, 2);
        lowRst = 1'b1;
        sStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", sBusy, 1'b0);
        check("midrst_done", sDone, 1'b0);
        check("midrst_ovf", sOvf, 1'b0);
        check("midrst_selc", sSelDecoC, 3'b111);
        lowRst = 1'b0;
        run_mul(8'd5, 8'd3, 1'b0);

        // Reset clears a sticky overflow left in IDLE
        run_mul(8'd255, 8'd255, 1'b0);
        @(negedge clk);
        lowRst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_clears_ovf", sOvf, 1'b0);
        lowRst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_shiftadd_ctrl.md
Name: mult_shiftadd_ctrl

Overview:
Sequencer for an unsigned shift-and-add multiply. It drives the existing register file (read decoders A/B, write decoder C) and the ALU select of the shared datapath. On sStart it computes R0 = R6 × R7 (low WIDTH bits), using R1 and R2 as working registers. It signals completion with a start/done handshake and flags truncation through a sticky overflow bit.

Parameters:
WIDTH, 8, datapath width; also the maximum number of loop iterations.
SELECTIONALU, 3, width of sSelAlu.
SELECTIONDECO, 3, width of each decoder select.

Ports:
clk  in  1  clock; all state updates on the rising edge.
lowRst  in  1  reset, synchronous, active-high.
sStart  in  1  start request, level; sampled only in IDLE and DONE.
sPar  in  1  ALU flag: current ALU result is even (LSB=0).
sZero  in  1  ALU flag: current ALU result is zero.
sCarry  in  1  ALU flag: carry/bit shifted out of the current ALU operation.
sSelDecoA  out  SELECTIONDECO  register driving ALU operand A.
sSelDecoB  out  SELECTIONDECO  register driving ALU operand B.
sSelDecoC  out  SELECTIONDECO  write destination; 3'b111 means no write.
sSelAlu  out  SELECTIONALU  ALU operation.
sBusy  out  1  high in every state except IDLE and DONE.
sDone  out  1  high in DONE.
sOvf  out  1  sticky overflow for the current or last operation.

Behaviour:
- ALU encodings: PASSA=000, ADD=001, SUB=010, SHL=100, SHR=101.
- Register map:
  - R6 = multiplicand input, R7 = multiplier input.
  - R0 = result, R1 = shifted multiplicand, R2 = shifted multiplier.
- Output style: Moore. All select outputs decode combinationally from the state register only. A write selected in a state commits on the rising edge that leaves that state. Flags are combinational from the ALU and are sampled on that same edge.
- States and outputs (listed as A, B, C, ALU):
  - IDLE: 000, 000, 111, PASSA. Go to CLR if sStart=1; on that edge clear cnt, sOvf and pend.
  - CLR: 110, 110, 000, SUB (R0 = 0). Go to LDA.
  - LDA: 110, 000, 001, PASSA (R1 = R6). Go to LDB.
  - LDB: 111, 000, 010, PASSA (R2 = R7). Go to TEST.
  - TEST: 010, 000, 111, PASSA. If sZero=1 or cnt==WIDTH, go to DONE. Otherwise go to ADD if sPar=0, else SHL.
  - ADD: 000, 001, 000, ADD (R0 = R0 + R1). If sCarry=1 or pend=1, set sOvf. Go to SHL.
  - SHL: 001, 000, 001, SHL (R1 = R1 << 1). If sCarry=1, set pend. Go to SHR.
  - SHR: 010, 000, 010, SHR (R2 = R2 >> 1). cnt = cnt + 1. Go to TEST.
  - DONE: 000, 000, 111, PASSA. Stay while sStart=1; go to IDLE when sStart=0.
- Pending bit: pend records that a set bit of the multiplicand was lost. sOvf is raised only if that lost bit is later added into R0.
- Start while busy: sStart in CLR..SHR is ignored.
- Counter: cnt is clog2(WIDTH+1) bits. It saturates logically: the loop exits at cnt==WIDTH, so it never wraps.
- Latency: 3 + Σ(3 or 4 per iteration) + 1 cycles from the start-sampling edge to DONE. The TEST that finds R2=0 costs 1 cycle.
- Reset: lowRst=1 at any edge, including mid-operation, forces:
  - state = IDLE; cnt = 0; pend = 0; sOvf = 0.
  - Outputs take IDLE values; sBusy = 0; sDone = 0.
  - Register-file contents are not touched.
- sOvf is held through DONE and IDLE until the next start.

Test Plan:
- R6=5, R7=3, sStart held high: sDone rises 12 edges after the start-sampling edge. R0=15 and sOvf=0. Sequence is CLR, LDA, LDB, then (TEST, ADD, SHL, SHR) ×2, TEST, DONE.
- R6=9, R7=0: DONE reached 4 edges after start (CLR, LDA, LDB, TEST). R0=0, and no ADD state is visited.
- WIDTH=8, R6=200, R7=2: SHL carry sets pend, and the following ADD raises sOvf=1. R0=144 (400 mod 256).
- WIDTH=8, R6=255, R7=255: loop exits on cnt==8 or on zero. R0=1 and sOvf=1. Check sBusy stays high throughout.
- Reset mid-run: assert lowRst during the second ADD. Next cycle is IDLE with sBusy=0, sDone=0, sOvf=0 and C=111. A fresh start with R6=5, R7=3 then yields R0=15.
- Handshake: keep sStart=1 after DONE; state stays DONE. Drop sStart; IDLE follows on the next edge. Pulse sStart while busy; no restart, and the cycle count is unchanged.
